// File: rtl/wb_stage.sv
// Write-back stage with MEM/WB register: sub-word load extract/extend, RF write port, forwarding copy, retire counter.
// Latency 1 cycle, every output is registered-state only; stall holds the register, flush loads a bubble (flush wins).
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_MEM_WB,
  input  logic [XLEN-1:0]   read_data_MEM_WB,
  input  logic [XLEN-1:0]   ALU_Result_MEM_WB,
  input  logic [XLEN-1:0]   pc_MEM_WB,
  input  logic [1:0]        MemtoReg_MEM_WB,
  input  logic              RegWrite_MEM_WB,
  input  logic [4:0]        write_reg_MEM_WB,
  input  logic [2:0]        load_type_MEM_WB,
  output logic              reg_write_en,
  output logic [4:0]        reg_write_addr,
  output logic [XLEN-1:0]   reg_write_data,
  output logic              fwd_en,
  output logic [4:0]        fwd_rd,
  output logic [XLEN-1:0]   fwd_data,
  output logic              misaligned_load,
  output logic              wb_valid,
  output logic [CNT_W-1:0]  retired_count
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] pc;
    logic [1:0]      memtoreg;
    logic            regwrite;
    logic [4:0]      rd;
    logic [2:0]      ltype;
  } wb_reg_t;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  wb_reg_t          wb_q;
  logic [CNT_W-1:0] retired_cnt;
  logic [1:0]       off;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [XLEN-1:0]  load_val;
  logic             mis_cond;
  logic [XLEN-1:0]  wdata;
  logic             wen;
  logic             mis;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_q        <= '0;
      retired_cnt <= '0;
    end else if (flush) begin
      // Only valid/regwrite matter for a bubble; the payload is left as-is.
      wb_q.valid    <= 1'b0;
      wb_q.regwrite <= 1'b0;
    end else if (!stall) begin
      wb_q.valid    <= valid_MEM_WB;
      wb_q.data     <= read_data_MEM_WB;
      wb_q.alu      <= ALU_Result_MEM_WB;
      wb_q.pc       <= pc_MEM_WB;
      wb_q.memtoreg <= MemtoReg_MEM_WB;
      wb_q.regwrite <= RegWrite_MEM_WB;
      wb_q.rd       <= write_reg_MEM_WB;
      wb_q.ltype    <= load_type_MEM_WB;
      if (valid_MEM_WB)
        retired_cnt <= retired_cnt + 1'b1;
    end
  end

  assign off = wb_q.alu[1:0];

  always_comb begin
    byte_sel = 8'h00;
    case (off)
      2'd0: byte_sel = wb_q.data[7:0];
      2'd1: byte_sel = wb_q.data[15:8];
      2'd2: byte_sel = wb_q.data[23:16];
      2'd3: byte_sel = wb_q.data[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = off[1] ? wb_q.data[31:16] : wb_q.data[15:0];
  end

  // Unlisted load codes fall through to full-word behaviour.
  always_comb begin
    load_val = wb_q.data;
    mis_cond = (off != 2'b00);
    case (wb_q.ltype)
      LT_LB: begin
        load_val = {{(XLEN-8){byte_sel[7]}}, byte_sel};
        mis_cond = 1'b0;
      end
      LT_LBU: begin
        load_val = {{(XLEN-8){1'b0}}, byte_sel};
        mis_cond = 1'b0;
      end
      LT_LH: begin
        load_val = {{(XLEN-16){half_sel[15]}}, half_sel};
        mis_cond = off[0];
      end
      LT_LHU: begin
        load_val = {{(XLEN-16){1'b0}}, half_sel};
        mis_cond = off[0];
      end
      default: begin
        load_val = wb_q.data;
        mis_cond = (off != 2'b00);
      end
    endcase
  end

  always_comb begin
    wdata = wb_q.alu;
    case (wb_q.memtoreg)
      2'b01:   wdata = load_val;
      2'b10:   wdata = wb_q.pc;
      default: wdata = wb_q.alu;
    endcase
  end

  assign mis = wb_q.valid & (wb_q.memtoreg == 2'b01) & mis_cond;
  assign wen = wb_q.valid & wb_q.regwrite & (wb_q.rd != 5'd0) & ~mis;

  assign reg_write_en    = wen;
  assign reg_write_addr  = wb_q.rd;
  assign reg_write_data  = wdata;
  assign fwd_en          = wen;
  assign fwd_rd          = wb_q.rd;
  assign fwd_data        = wdata;
  assign misaligned_load = mis;
  assign wb_valid        = wb_q.valid;
  assign retired_count   = retired_cnt;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: driver pushes hand-computed expectations tagged with their cycle,
// a negedge monitor pops and compares them against the write-back outputs.
module tb_wb_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        valid_MEM_WB;
  logic [31:0] read_data_MEM_WB;
  logic [31:0] ALU_Result_MEM_WB;
  logic [31:0] pc_MEM_WB;
  logic [1:0]  MemtoReg_MEM_WB;
  logic        RegWrite_MEM_WB;
  logic [4:0]  write_reg_MEM_WB;
  logic [2:0]  load_type_MEM_WB;
  logic        reg_write_en;
  logic [4:0]  reg_write_addr;
  logic [31:0] reg_write_data;
  logic        fwd_en;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        misaligned_load;
  logic        wb_valid;
  logic [31:0] retired_count;

  wb_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_MEM_WB(valid_MEM_WB), .read_data_MEM_WB(read_data_MEM_WB),
    .ALU_Result_MEM_WB(ALU_Result_MEM_WB), .pc_MEM_WB(pc_MEM_WB),
    .MemtoReg_MEM_WB(MemtoReg_MEM_WB), .RegWrite_MEM_WB(RegWrite_MEM_WB),
    .write_reg_MEM_WB(write_reg_MEM_WB), .load_type_MEM_WB(load_type_MEM_WB),
    .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr),
    .reg_write_data(reg_write_data), .fwd_en(fwd_en), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .misaligned_load(misaligned_load),
    .wb_valid(wb_valid), .retired_count(retired_count)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic        full;
    logic        valid;
    logic        en;
    logic        mis;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          cyc_cnt = 0;
  int          tests   = 0;
  int          fails   = 0;
  logic [31:0] exp_cnt = 0;
  logic        last_valid = 0;
  localparam logic [31:0] D = 32'h80FF_7F01;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.name, " cycle"}, cyc_cnt, e.cyc);
      chk({e.name, " wb_valid"}, {31'd0, wb_valid}, {31'd0, e.valid});
      chk({e.name, " en"}, {31'd0, reg_write_en}, {31'd0, e.en});
      chk({e.name, " fwd_en"}, {31'd0, fwd_en}, {31'd0, e.en});
      chk({e.name, " misaligned"}, {31'd0, misaligned_load}, {31'd0, e.mis});
      chk({e.name, " count"}, retired_count, e.cnt);
      if (e.full) begin
        chk({e.name, " addr"}, {27'd0, reg_write_addr}, {27'd0, e.addr});
        chk({e.name, " fwd_rd"}, {27'd0, fwd_rd}, {27'd0, e.addr});
        chk({e.name, " data"}, reg_write_data, e.data);
        chk({e.name, " fwd_data"}, fwd_data, e.data);
      end
    end
  end

  task automatic issue(input string name, input logic v, input logic [31:0] rdat,
                       input logic [31:0] alu, input logic [31:0] pc, input logic [1:0] m2r,
                       input logic rw, input logic [4:0] rd, input logic [2:0] lt,
                       input logic st, input logic fl, input logic full,
                       input logic e_en, input logic e_mis, input logic [4:0] e_addr,
                       input logic [31:0] e_data);
    exp_t e;
    @(posedge clk);
    #2;
    valid_MEM_WB = v; read_data_MEM_WB = rdat; ALU_Result_MEM_WB = alu;
    pc_MEM_WB = pc; MemtoReg_MEM_WB = m2r; RegWrite_MEM_WB = rw;
    write_reg_MEM_WB = rd; load_type_MEM_WB = lt; stall = st; flush = fl;
    if (fl) last_valid = 1'b0;
    else if (!st) begin
      last_valid = v;
      if (v) exp_cnt = exp_cnt + 1;
    end
    e.cyc = cyc_cnt + 1; e.name = name; e.full = full; e.valid = last_valid;
    e.en = e_en; e.mis = e_mis; e.addr = e_addr; e.data = e_data; e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic ld(input string name, input logic [31:0] alu, input logic [2:0] lt,
                    input logic e_en, input logic e_mis, input logic [31:0] e_data);
    issue(name, 1'b1, D, alu, 32'h0, 2'b01, 1'b1, 5'd3, lt, 1'b0, 1'b0, 1'b1,
          e_en, e_mis, 5'd3, e_data);
  endtask

  task automatic idle_inputs();
    valid_MEM_WB = 0; read_data_MEM_WB = 0; ALU_Result_MEM_WB = 0; pc_MEM_WB = 0;
    MemtoReg_MEM_WB = 0; RegWrite_MEM_WB = 0; write_reg_MEM_WB = 0;
    load_type_MEM_WB = 0; stall = 0; flush = 0;
  endtask

  task automatic check_zero(input string name);
    chk({name, " wb_valid"}, {31'd0, wb_valid}, 32'd0);
    chk({name, " en"}, {31'd0, reg_write_en}, 32'd0);
    chk({name, " addr"}, {27'd0, reg_write_addr}, 32'd0);
    chk({name, " data"}, reg_write_data, 32'd0);
    chk({name, " fwd"}, {26'd0, fwd_en, fwd_rd}, 32'd0);
    chk({name, " fwd_data"}, fwd_data, 32'd0);
    chk({name, " misaligned"}, {31'd0, misaligned_load}, 32'd0);
    chk({name, " count"}, retired_count, 32'd0);
  endtask

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    #12;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    issue("alu_rd5", 1, 0, 32'h0000_1234, 0, 2'b00, 1, 5'd5, 3'b010, 0, 0, 1, 1, 0, 5'd5, 32'h0000_1234);
    issue("alu_rd0", 1, 0, 32'h0000_1234, 0, 2'b00, 1, 5'd0, 3'b010, 0, 0, 1, 0, 0, 5'd0, 32'h0000_1234);
    ld("lb_off0",  32'h100, 3'b000, 1, 0, 32'h0000_0001);
    ld("lb_off1",  32'h101, 3'b000, 1, 0, 32'h0000_007F);
    ld("lb_off2",  32'h102, 3'b000, 1, 0, 32'hFFFF_FFFF);
    ld("lb_off3",  32'h103, 3'b000, 1, 0, 32'hFFFF_FF80);
    ld("lbu_off3", 32'h103, 3'b100, 1, 0, 32'h0000_0080);
    ld("lbu_off2", 32'h102, 3'b100, 1, 0, 32'h0000_00FF);
    ld("lh_off2",  32'h102, 3'b001, 1, 0, 32'hFFFF_80FF);
    ld("lhu_off2", 32'h102, 3'b101, 1, 0, 32'h0000_80FF);
    ld("lh_off0",  32'h100, 3'b001, 1, 0, 32'h0000_7F01);
    ld("lh_off1",  32'h101, 3'b001, 0, 1, 32'h0000_7F01);
    ld("lhu_off3", 32'h103, 3'b101, 0, 1, 32'h0000_80FF);
    ld("lw_off2",  32'h102, 3'b010, 0, 1, 32'h80FF_7F01);
    ld("lw_off0",  32'h100, 3'b010, 1, 0, 32'h80FF_7F01);
    ld("badlt_off1", 32'h101, 3'b111, 0, 1, 32'h80FF_7F01);
    issue("alu_off3_not_load", 1, D, 32'h0000_0003, 0, 2'b00, 1, 5'd4, 3'b010, 0, 0, 1, 1, 0, 5'd4, 32'h0000_0003);
    issue("pc_wb", 1, D, 32'h0000_0055, 32'h0000_0104, 2'b10, 1, 5'd1, 3'b010, 0, 0, 1, 1, 0, 5'd1, 32'h0000_0104);
    issue("m2r11_alu", 1, D, 32'h0000_ABCD, 32'h0000_0104, 2'b11, 1, 5'd2, 3'b010, 0, 0, 1, 1, 0, 5'd2, 32'h0000_ABCD);

    // Asynchronous reset between edges must clear everything without a clock edge.
    @(posedge clk); #2; idle_inputs();
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    exp_cnt = 0; last_valid = 0;
    #1 reset = 1'b0;

    issue("after_rst", 1, 0, 32'h0000_0011, 0, 2'b00, 1, 5'd7, 3'b010, 0, 0, 1, 1, 0, 5'd7, 32'h0000_0011);
    issue("ld2", 1, 0, 32'h0000_0022, 0, 2'b00, 1, 5'd8, 3'b010, 0, 0, 1, 1, 0, 5'd8, 32'h0000_0022);
    issue("ld3", 1, 0, 32'h0000_0033, 0, 2'b00, 1, 5'd9, 3'b010, 0, 0, 1, 1, 0, 5'd9, 32'h0000_0033);
    issue("stall1", 1, 0, 32'h0000_0044, 0, 2'b00, 1, 5'd10, 3'b010, 1, 0, 1, 1, 0, 5'd9, 32'h0000_0033);
    issue("stall2", 1, 0, 32'h0000_0055, 0, 2'b00, 1, 5'd11, 3'b010, 1, 0, 1, 1, 0, 5'd9, 32'h0000_0033);
    issue("flush_stall", 1, 0, 32'h0000_0066, 0, 2'b00, 1, 5'd12, 3'b010, 1, 1, 0, 0, 0, 5'd0, 32'h0);
    issue("bubble_misfields", 0, D, 32'h0000_0102, 0, 2'b01, 1, 5'd13, 3'b010, 0, 0, 1, 0, 0, 5'd13, 32'h80FF_7F01);

    // Counter wrap: preload all-ones into the counter register.
    @(posedge clk); #2; valid_MEM_WB = 0;
    @(negedge clk); #1;
    force dut.retired_cnt = 32'hFFFF_FFFF;
    #1 release dut.retired_cnt;
    #1 chk("preload count", retired_count, 32'hFFFF_FFFF);
    exp_cnt = 32'hFFFF_FFFF;
    issue("wrap", 1, 0, 32'h0000_0077, 0, 2'b00, 1, 5'd14, 3'b010, 0, 0, 1, 1, 0, 5'd14, 32'h0000_0077);

    @(posedge clk); #2; idle_inputs();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk); #1;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
